iob_uart16550_ctrl: RTL and testbench
=====================================

# iob_uart16550_ctrl

Autonomous IOb-bus master that configures and services the iob_uart16550 core. After reset it programs the divisor latch, line control and FIFO control registers. It then polls the Line Status Register and moves bytes between valid/ready byte streams and the UART's THR/RBR. It sits between a byte-stream producer/consumer (e.g. a console or loader FSM) and the UART's IOb slave port, so no CPU is needed for the serial link.

## Interface
Parameters:
- DIV, 16'd27, divisor latch value (DLM:DLL) written at init.
- LCR_VAL, 8'h03, line control value (8N1) written after divisor.
- FCR_VAL, 8'h07, FIFO control value (enable, clear RX/TX FIFOs).
- POLL_GAP, 8, idle cycles between the end of one LSR read and the next LSR read issue; 0 allowed.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- iob_avalid_o  out  1  bus request valid.
- iob_addr_o  out  3  UART byte address.
- iob_wdata_o  out  32  write data; byte placed on lane addr[1:0].
- iob_wstrb_o  out  4  byte strobe; 0 for reads, else 1<<addr[1:0].
- iob_ready_i  in  1  request accepted.
- iob_rvalid_i  in  1  transaction complete (reads and writes).
- iob_rdata_i  in  32  read data; byte taken from lane addr[1:0].
- tx_data_i  in  8  byte to transmit.
- tx_valid_i  in  1  tx byte available.
- tx_ready_o  out  1  one-cycle pulse: tx byte consumed.
- rx_data_o  out  8  received byte.
- rx_valid_o  out  1  rx byte held.
- rx_ready_i  in  1  consumer takes rx byte.
- init_done_o  out  1  high once init sequence completes.
- lsr_err_o  out  4  sticky OR of LSR[4:1] (BI,FE,PE,OE).
- err_clr_i  in  1  clears lsr_err_o.

## Operation
- States: RST, W_LCR_DLAB, W_DLL, W_DLM, W_LCR, W_FCR, GAP, RD_LSR, RD_RBR, WR_THR.
- Init writes, in order: addr 3 = LCR_VAL|8'h80; addr 0 = DIV[7:0]; addr 1 = DIV[15:8]; addr 3 = LCR_VAL&8'h7F; addr 2 = FCR_VAL. Then init_done_o=1, go to GAP.
- GAP: count POLL_GAP cycles, then RD_LSR (addr 5).
- After the LSR read completes, with DR=LSR[0] and THRE=LSR[5]:
  - DR=1 and rx holding register empty: go to RD_RBR (addr 0).
  - Otherwise, THRE=1 and tx_valid_i=1: go to WR_THR (addr 0, wdata lane0=tx_data_i).
  - Otherwise: go to GAP.
- RX has priority over TX when both qualify. Each RD_RBR or WR_THR returns to GAP.
- RD_RBR completion loads rx_data_o and sets rx_valid_o. rx_valid_o clears on rx_valid_o&rx_ready_i.
- WR_THR: tx_ready_o pulses in the completion cycle. tx_data_i is sampled at request issue and must stay stable until then.
- lsr_err_o |= LSR[4:1] on every LSR read completion. err_clr_i has priority over a same-cycle set.

## Timing
- Reset values: state RST; iob_avalid_o=0, iob_addr_o=0, iob_wdata_o=0, iob_wstrb_o=0, tx_ready_o=0, rx_data_o=0, rx_valid_o=0, init_done_o=0, lsr_err_o=0.
- RST moves to W_LCR_DLAB on the first cycle with rst_i=0.
- Transaction protocol:
  - avalid/addr/wdata/wstrb are registered and held until a cycle with iob_ready_i=1. avalid drops on the next edge.
  - The controller then waits for iob_rvalid_i, which may coincide with the ready cycle.
  - The next request issues no earlier than the cycle after rvalid.
  - Only one transaction is ever outstanding.
- Minimum transaction length: 2 cycles (issue cycle, then ready+rvalid cycle).
- GAP counter is 8 bits and loads POLL_GAP on entry. POLL_GAP=0 means RD_LSR issues on the cycle after the previous completion.
- rst_i mid-transaction: the controller returns to RST next edge and drops avalid. Any rvalid arriving in RST or during the following init is ignored until that state's own request issues.
- rx byte is never overwritten while rx_valid_o=1; RBR is not read in that case.

## Configuration
- IOB_UART16550_CTRL_RX_EN defined: RX path as described.
- Undefined: no RD_RBR state, DR ignored; rx_valid_o tied 0, rx_data_o tied 0, rx_ready_i unused. TX and error logic are unchanged.

## Test plan
- Reset release with DIV=16'd27, LCR_VAL=8'h03, FCR_VAL=8'h07 -> writes exactly (3,0x83),(0,0x1B),(1,0x00),(3,0x03),(2,0x07) on correct lanes/strobes; init_done_o=1 after the fifth rvalid.
- tx_valid_i=1, tx_data_i=0x5A, LSR returns 0x60 -> THR write lane0=0x5A, wstrb=4'b0001, tx_ready_o single-cycle pulse; loopback model sees 0x5A on txd.
- LSR=0x61, RBR=0xA5, tx_valid_i=1 -> RBR read before THR write; rx_data_o=0xA5, rx_valid_o=1. With rx_ready_i=0, later DR=1 polls issue no RBR read.
- LSR=0x62 once -> lsr_err_o=4'b0001 and stays there through LSR=0x60 polls; err_clr_i pulse -> 0.
- Slave delays ready 3 cycles and rvalid 2 more -> avalid held exactly until ready, no new request before rvalid; rst_i asserted mid-WR_THR -> avalid=0 next cycle and init restarts cleanly.
- Build without IOB_UART16550_CTRL_RX_EN, LSR=0x61 -> no addr-0 reads, rx_valid_o stays 0.

Source files
------------

// File: rtl/iob_uart16550_ctrl.sv
// iob_uart16550_ctrl
// Autonomous IOb-bus master for the iob_uart16550 core.
// After reset it programs the divisor latch, LCR and FCR. It then polls LSR
// and moves bytes between valid/ready byte streams and THR/RBR.
// Build option: define IOB_UART16550_CTRL_RX_EN to include the receive path.
// Without it, DR is ignored and the rx stream outputs are held at zero.
//
// state        | meaning
// S_RST        | idle after reset, issues the first init write next cycle
// S_W_LCR_DLAB | LCR write with DLAB set
// S_W_DLL      | divisor low byte write
// S_W_DLM      | divisor high byte write
// S_W_LCR      | LCR write with DLAB cleared
// S_W_FCR      | FIFO control write, last init step
// S_GAP        | idle countdown between LSR polls
// S_RD_LSR     | line status read
// S_RD_RBR     | receive buffer read (RX build only)
// S_WR_THR     | transmit holding register write
module iob_uart16550_ctrl #(
  parameter logic [15:0] DIV      = 16'd27,
  parameter logic [7:0]  LCR_VAL  = 8'h03,
  parameter logic [7:0]  FCR_VAL  = 8'h07,
  parameter int unsigned POLL_GAP = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        iob_avalid_o,
  output logic [2:0]  iob_addr_o,
  output logic [31:0] iob_wdata_o,
  output logic [3:0]  iob_wstrb_o,
  input  logic        iob_ready_i,
  input  logic        iob_rvalid_i,
  input  logic [31:0] iob_rdata_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        init_done_o,
  output logic [3:0]  lsr_err_o,
  input  logic        err_clr_i
);

  localparam logic [2:0] A_DAT = 3'd0;  // RBR/THR/DLL share address 0
  localparam logic [2:0] A_DLM = 3'd1;
  localparam logic [2:0] A_FCR = 3'd2;
  localparam logic [2:0] A_LCR = 3'd3;
  localparam logic [2:0] A_LSR = 3'd5;

  localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP);

  typedef enum logic [3:0] {
    S_RST,
    S_W_LCR_DLAB,
    S_W_DLL,
    S_W_DLM,
    S_W_LCR,
    S_W_FCR,
    S_GAP,
    S_RD_LSR,
    S_WR_THR
`ifdef IOB_UART16550_CTRL_RX_EN
    , S_RD_RBR
`endif
  } state_t;

  // With no gap the next LSR read issues straight from the completion edge.
  localparam state_t S_GAP_TGT = (POLL_GAP == 0) ? S_RD_LSR : S_GAP;

  // Place a byte on the lane selected by the low address bits.
  function automatic logic [31:0] f_lane(input logic [2:0] a, input logic [7:0] b);
    logic [31:0] v;
    v = 32'(b) << {a[1:0], 3'b000};
    return v;
  endfunction

  function automatic logic [3:0] f_strb(input logic [2:0] a);
    logic [3:0] s;
    s = 4'b0001 << a[1:0];
    return s;
  endfunction

  state_t      r_state;
  logic        r_avalid;
  logic [2:0]  r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_wait;
  logic [7:0]  r_gap;
  logic        r_tx_ready;
  logic        r_init_done;
  logic [3:0]  r_lsr_err;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;

  logic [7:0]  w_rbyte;
  logic        w_accept;
  logic        w_done;

  // Read data byte comes from the lane of the outstanding request's address.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_rbyte = iob_rdata_i[7:0];
      2'd1:    w_rbyte = iob_rdata_i[15:8];
      2'd2:    w_rbyte = iob_rdata_i[23:16];
      default: w_rbyte = iob_rdata_i[31:24];
    endcase
  end

  // rvalid only counts once our own request was accepted (same cycle or later),
  // so stray completions after a reset are ignored.
  assign w_accept = r_avalid & iob_ready_i;
  assign w_done   = iob_rvalid_i & (w_accept | r_wait);

  // Controller FSM: init sequence, LSR polling, data moves and status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_RST;
      r_avalid    <= 1'b0;
      r_addr      <= 3'd0;
      r_wdata     <= 32'd0;
      r_wstrb     <= 4'd0;
      r_wait      <= 1'b0;
      r_gap       <= 8'd0;
      r_tx_ready  <= 1'b0;
      r_init_done <= 1'b0;
      r_lsr_err   <= 4'd0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
    end else begin
      r_tx_ready <= 1'b0;

      // Bus handshake: drop avalid on accept, remember if rvalid is still due.
      if (w_accept) begin
        r_avalid <= 1'b0;
        r_wait   <= ~iob_rvalid_i;
      end else if (r_wait && iob_rvalid_i) begin
        r_wait <= 1'b0;
      end

      if (err_clr_i) begin
        r_lsr_err <= 4'd0;
      end else if (r_state == S_RD_LSR && w_done) begin
        r_lsr_err <= r_lsr_err | w_rbyte[4:1];
      end

`ifdef IOB_UART16550_CTRL_RX_EN
      if (r_rx_valid && rx_ready_i) begin
        r_rx_valid <= 1'b0;
      end
      if (r_state == S_RD_RBR && w_done) begin
        r_rx_data  <= w_rbyte;
        r_rx_valid <= 1'b1;
      end
`endif

      // A new request is only issued on a completion edge (or from RST/GAP),
      // so these assignments override the accept-clear above when both apply.
      case (r_state)
        S_RST: begin
          r_state  <= S_W_LCR_DLAB;
          r_avalid <= 1'b1;
          r_addr   <= A_LCR;
          r_wdata  <= f_lane(A_LCR, LCR_VAL | 8'h80);
          r_wstrb  <= f_strb(A_LCR);
        end
        S_W_LCR_DLAB: if (w_done) begin
          r_state  <= S_W_DLL;
          r_avalid <= 1'b1;
          r_addr   <= A_DAT;
          r_wdata  <= f_lane(A_DAT, DIV[7:0]);
          r_wstrb  <= f_strb(A_DAT);
        end
        S_W_DLL: if (w_done) begin
          r_state  <= S_W_DLM;
          r_avalid <= 1'b1;
          r_addr   <= A_DLM;
          r_wdata  <= f_lane(A_DLM, DIV[15:8]);
          r_wstrb  <= f_strb(A_DLM);
        end
        S_W_DLM: if (w_done) begin
          r_state  <= S_W_LCR;
          r_avalid <= 1'b1;
          r_addr   <= A_LCR;
          r_wdata  <= f_lane(A_LCR, LCR_VAL & 8'h7F);
          r_wstrb  <= f_strb(A_LCR);
        end
        S_W_LCR: if (w_done) begin
          r_state  <= S_W_FCR;
          r_avalid <= 1'b1;
          r_addr   <= A_FCR;
          r_wdata  <= f_lane(A_FCR, FCR_VAL);
          r_wstrb  <= f_strb(A_FCR);
        end
        S_GAP: begin
          if (r_gap == 8'd1) begin
            r_state  <= S_RD_LSR;
            r_avalid <= 1'b1;
            r_addr   <= A_LSR;
            r_wdata  <= 32'd0;
            r_wstrb  <= 4'd0;
          end
          r_gap <= r_gap - 8'd1;
        end
        S_RD_LSR: if (w_done) begin
`ifdef IOB_UART16550_CTRL_RX_EN
          // RX wins over TX; a held rx byte blocks further RBR reads.
          if (w_rbyte[0] && !r_rx_valid) begin
            r_state  <= S_RD_RBR;
            r_avalid <= 1'b1;
            r_addr   <= A_DAT;
            r_wdata  <= 32'd0;
            r_wstrb  <= 4'd0;
          end else
`endif
          if (w_rbyte[5] && tx_valid_i) begin
            r_state  <= S_WR_THR;
            r_avalid <= 1'b1;
            r_addr   <= A_DAT;
            r_wdata  <= f_lane(A_DAT, tx_data_i);
            r_wstrb  <= f_strb(A_DAT);
          end else begin
            r_state <= S_GAP_TGT;
            r_gap   <= GAP_LOAD;
            if (POLL_GAP == 0) begin
              r_avalid <= 1'b1;
              r_addr   <= A_LSR;
              r_wdata  <= 32'd0;
              r_wstrb  <= 4'd0;
            end
          end
        end
        default: if (w_done) begin
          // S_W_FCR, S_WR_THR and S_RD_RBR all fall back to polling.
          if (r_state == S_W_FCR) begin
            r_init_done <= 1'b1;
          end
          if (r_state == S_WR_THR) begin
            r_tx_ready <= 1'b1;
          end
          r_state <= S_GAP_TGT;
          r_gap   <= GAP_LOAD;
          if (POLL_GAP == 0) begin
            r_avalid <= 1'b1;
            r_addr   <= A_LSR;
            r_wdata  <= 32'd0;
            r_wstrb  <= 4'd0;
          end
        end
      endcase
    end
  end

  assign iob_avalid_o = r_avalid;
  assign iob_addr_o   = r_addr;
  assign iob_wdata_o  = r_wdata;
  assign iob_wstrb_o  = r_wstrb;
  assign tx_ready_o   = r_tx_ready;
  assign init_done_o  = r_init_done;
  assign lsr_err_o    = r_lsr_err;

`ifdef IOB_UART16550_CTRL_RX_EN
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
`else
  assign rx_data_o  = 8'd0;
  assign rx_valid_o = 1'b0;

  // Receive-side inputs and status bits have no consumer in this build.
  logic w_unused_rx;
  assign w_unused_rx = ^{rx_ready_i, w_rbyte[0], w_rbyte[7:6], r_rx_data, r_rx_valid};
`endif

endmodule

// File: tb/tb_iob_uart16550_ctrl.sv
// Scoreboard bench for iob_uart16550_ctrl: a UART slave model answers the
// bus, expected non-poll requests are queued by the stimulus and checked by
// a separate monitor when the DUT's request is accepted.
module tb_iob_uart16550_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        iob_avalid_o;
  logic [2:0]  iob_addr_o;
  logic [31:0] iob_wdata_o;
  logic [3:0]  iob_wstrb_o;
  logic        iob_ready_i;
  logic        iob_rvalid_i;
  logic [31:0] iob_rdata_i;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        init_done_o;
  logic [3:0]  lsr_err_o;
  logic        err_clr_i;

  iob_uart16550_ctrl #(
    .DIV(16'd27), .LCR_VAL(8'h03), .FCR_VAL(8'h07), .POLL_GAP(3)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o),
    .iob_wdata_o(iob_wdata_o), .iob_wstrb_o(iob_wstrb_o),
    .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
    .iob_rdata_i(iob_rdata_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .init_done_o(init_done_o), .lsr_err_o(lsr_err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          chk_wd;
  } req_t;

  req_t       exp_q[$];
  logic [7:0] lsr_q[$];
  int         tot = 0;
  int         bad = 0;
  int         rdy_dly = 0;
  int         rv_dly = 0;
  logic [7:0] rbr_val = 8'h00;
  int         n_done = 0;
  int         n_lsr_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tot++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // UART slave model with programmable ready and rvalid latency.
  initial begin : slave
    int         ph;
    int         cnt;
    logic [2:0] a;
    logic       rd;
    logic [7:0] rb;
    bit         acc;
    bit         rsp;
    ph = 0; cnt = 0; a = 3'd0; rd = 1'b0; rb = 8'd0;
    iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = 32'd0;
    forever begin
      @(negedge clk_i);
      iob_ready_i  = 1'b0;
      iob_rvalid_i = 1'b0;
      acc = 0;
      rsp = 0;
      if (rst_i) begin
        ph = 0;
      end else begin
        case (ph)
          0: if (iob_avalid_o) begin
            if (rdy_dly == 0) acc = 1;
            else begin cnt = rdy_dly; ph = 1; end
          end
          1: begin
            chk("avalid_held_until_ready", iob_avalid_o, 1);
            cnt--;
            if (cnt == 0) acc = 1;
          end
          default: begin
            chk("no_request_before_rvalid", iob_avalid_o, 0);
            cnt--;
            if (cnt == 0) rsp = 1;
          end
        endcase
        if (acc) begin
          iob_ready_i = 1'b1;
          a  = iob_addr_o;
          rd = (iob_wstrb_o == 4'd0);
          rb = 8'd0;
          if (rd && a == 3'd5) begin
            if (lsr_q.size() > 0) rb = lsr_q.pop_front();
            else rb = 8'h60;
          end else if (rd && a == 3'd0) begin
            rb = rbr_val;
          end
          if (rv_dly == 0) rsp = 1;
          else begin cnt = rv_dly; ph = 2; end
        end
        if (rsp) begin
          iob_rvalid_i = 1'b1;
          iob_rdata_i  = 32'hEEEE_EEEE;
          iob_rdata_i[8*int'(a[1:0]) +: 8] = rb;
          n_done++;
          if (rd && a == 3'd5) n_lsr_done++;
          ph = 0;
        end
      end
    end
  end

  // Monitor: every accepted non-poll request is checked against the queue.
  always @(negedge clk_i) begin
    req_t e;
    #1;
    if (!rst_i && iob_avalid_o && iob_ready_i) begin
      if (iob_addr_o == 3'd5 && iob_wstrb_o == 4'd0) begin
        // LSR poll, timing-dependent, not queued
      end else if (exp_q.size() == 0) begin
        tot++;
        bad++;
        $display("FAIL unexpected_request: addr=%0d wdata=0x%08h wstrb=%b, none queued",
                 iob_addr_o, iob_wdata_o, iob_wstrb_o);
      end else begin
        e = exp_q.pop_front();
        chk("req_addr", 32'(iob_addr_o), 32'(e.addr));
        chk("req_wstrb", 32'(iob_wstrb_o), 32'(e.wstrb));
        if (e.chk_wd) chk("req_wdata", iob_wdata_o, e.wdata);
      end
    end
  end

  task automatic push_init();
    exp_q.push_back('{3'd3, 32'h8300_0000, 4'b1000, 1'b1});
    exp_q.push_back('{3'd0, 32'h0000_001B, 4'b0001, 1'b1});
    exp_q.push_back('{3'd1, 32'h0000_0000, 4'b0010, 1'b1});
    exp_q.push_back('{3'd3, 32'h0300_0000, 4'b1000, 1'b1});
    exp_q.push_back('{3'd2, 32'h0007_0000, 4'b0100, 1'b1});
  endtask

  task automatic wait_init(input int base);
    int k;
    k = 0;
    while (!init_done_o && k < 400) begin @(negedge clk_i); k++; end
    chk("init_done", 32'(init_done_o), 1);
    chk("init_rvalid_count", 32'(n_done - base), 5);
    chk("init_writes_consumed", 32'(exp_q.size()), 0);
  endtask

  // Returns just after an LSR completion, while the DUT sits in GAP.
  task automatic wait_poll();
    int s;
    int k;
    s = n_lsr_done;
    k = 0;
    while (n_lsr_done == s && k < 500) begin @(negedge clk_i); k++; end
    if (n_lsr_done == s) timeout("wait_poll");
    @(negedge clk_i);
  endtask

  task automatic wait_txr(input string name);
    int k;
    k = 0;
    while (!tx_ready_o && k < 500) begin @(negedge clk_i); k++; end
    if (!tx_ready_o) timeout(name);
    else begin
      tx_valid_i = 1'b0;
      @(negedge clk_i);
      chk({name, "_pulse_width"}, 32'(tx_ready_o), 0);
    end
  endtask

  initial begin : stim
    int base;
    int k;
    rst_i = 1'b1; tx_valid_i = 1'b0; tx_data_i = 8'h00;
    rx_ready_i = 1'b0; err_clr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_avalid", 32'(iob_avalid_o), 0);
    chk("rst_addr", 32'(iob_addr_o), 0);
    chk("rst_wdata", iob_wdata_o, 0);
    chk("rst_wstrb", 32'(iob_wstrb_o), 0);
    chk("rst_tx_ready", 32'(tx_ready_o), 0);
    chk("rst_rx_data", 32'(rx_data_o), 0);
    chk("rst_rx_valid", 32'(rx_valid_o), 0);
    chk("rst_init_done", 32'(init_done_o), 0);
    chk("rst_lsr_err", 32'(lsr_err_o), 0);

    // Init sequence
    push_init();
    base = n_done;
    rst_i = 1'b0;
    wait_init(base);

    // Plain TX
    wait_poll();
    tx_data_i = 8'h5A; tx_valid_i = 1'b1;
    exp_q.push_back('{3'd0, 32'h0000_005A, 4'b0001, 1'b1});
    wait_txr("tx_5a");

    // Sticky LSR error and clear
    wait_poll();
    lsr_q.push_back(8'h62);
    k = 0;
    while (lsr_err_o == 4'd0 && k < 300) begin @(negedge clk_i); k++; end
    chk("lsr_err_set", 32'(lsr_err_o), 32'h1);
    repeat (40) @(negedge clk_i);
    chk("lsr_err_sticky", 32'(lsr_err_o), 32'h1);
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    @(negedge clk_i);
    chk("lsr_err_clr", 32'(lsr_err_o), 0);

    // DR=1 with a tx byte waiting
    wait_poll();
    rbr_val = 8'hA5; tx_data_i = 8'h3C; tx_valid_i = 1'b1;
    lsr_q.push_back(8'h61);
`ifdef IOB_UART16550_CTRL_RX_EN
    exp_q.push_back('{3'd0, 32'h0, 4'b0000, 1'b0});
`endif
    exp_q.push_back('{3'd0, 32'h0000_003C, 4'b0001, 1'b1});
    wait_txr("tx_3c");
    repeat (3) lsr_q.push_back(8'h61);
    repeat (4) wait_poll();
`ifdef IOB_UART16550_CTRL_RX_EN
    chk("rx_valid_held", 32'(rx_valid_o), 1);
    chk("rx_data_held", 32'(rx_data_o), 32'hA5);
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
    chk("rx_valid_cleared", 32'(rx_valid_o), 0);
`else
    chk("rx_valid_tied", 32'(rx_valid_o), 0);
    chk("rx_data_tied", 32'(rx_data_o), 0);
`endif

    // Slow slave: ready after 3 cycles, rvalid 2 cycles later
    wait_poll();
    rdy_dly = 3; rv_dly = 2;
    tx_data_i = 8'hC7; tx_valid_i = 1'b1;
    exp_q.push_back('{3'd0, 32'h0000_00C7, 4'b0001, 1'b1});
    wait_txr("tx_slow");

    // Reset while a THR write waits for ready
    wait_poll();
    rdy_dly = 6; rv_dly = 1;
    tx_data_i = 8'h99; tx_valid_i = 1'b1;
    k = 0;
    while (!(iob_avalid_o && iob_addr_o == 3'd0 && iob_wstrb_o == 4'b0001) && k < 400) begin
      @(negedge clk_i);
      k++;
    end
    if (!(iob_avalid_o && iob_addr_o == 3'd0 && iob_wstrb_o == 4'b0001)) timeout("thr_in_flight");
    rst_i = 1'b1;
    tx_valid_i = 1'b0;
    @(negedge clk_i);
    chk("midrst_avalid", 32'(iob_avalid_o), 0);
    chk("midrst_init_done", 32'(init_done_o), 0);
    chk("midrst_tx_ready", 32'(tx_ready_o), 0);
    rdy_dly = 1; rv_dly = 0;
    push_init();
    @(negedge clk_i);
    base = n_done;
    rst_i = 1'b0;
    wait_init(base);

    repeat (20) @(negedge clk_i);
    chk("exp_queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
